// File: rtl/opseq_pkg.sv
// Shared types and defaults for the op-unit sequencer (opseq_ctrl, opseq_bank).
package opseq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] SEL_0 = 2'b00;
  localparam logic [1:0] SEL_1 = 2'b01;
  localparam logic [1:0] SEL_2 = 2'b10;
  localparam logic [1:0] SEL_3 = 2'b11;

  localparam int DEF_W    = 5;
  localparam int DEF_HOLD = 2;

  // Hold counter is sized for the full legal 1..15 range.
  localparam int CNT_W = 4;

endpackage

// File: rtl/opseq_bank.sv
// 4xW result register file: synchronous write/clear, combinational read.
module opseq_bank
  import opseq_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         we,
  input  logic [1:0]   wa,
  input  logic [W-1:0] wd,
  input  logic [1:0]   ra,
  output logic [W-1:0] rd
);

  logic [3:0][W-1:0] mem;

  always_ff @(posedge clk) begin
    if (clr) begin
      mem <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (we && (wa == 2'(i))) mem[i] <= wd;
      end
    end
  end

  assign rd = mem[ra];

endmodule

// File: rtl/opseq_ctrl.sv
// Sequencer driving the 2-bit-select op unit through 00..11 and capturing Y per select.
// Optional XOR checksum output chk is enabled by defining OPSEQ_XOR_CHK_EN.
module opseq_ctrl
  import opseq_pkg::*;
#(
  parameter int W           = DEF_W,
  parameter int HOLD_CYCLES = DEF_HOLD
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic [1:0]   op_s,
  output logic [W-1:0] op_a,
  output logic [W-1:0] op_b,
  input  logic [W-1:0] op_y,
  output logic         busy,
  output logic         res_valid,
  output logic [1:0]   res_sel,
  output logic [W-1:0] res_data,
  input  logic [1:0]   rd_sel,
  output logic [W-1:0] rd_data,
`ifdef OPSEQ_XOR_CHK_EN
  output logic         done,
  output logic [W-1:0] chk
`else
  output logic         done
`endif
);

  localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             cap;

  // Capture happens on the last cycle a select is held.
  assign cap = (state == DRIVE) && (cnt == '0);

  opseq_bank #(.W(W)) u_bank (
    .clk (clk),
    .clr (rst),
    .we  (cap),
    .wa  (op_s),
    .wd  (op_y),
    .ra  (rd_sel),
    .rd  (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_s      <= SEL_0;
      op_a      <= '0;
      op_b      <= '0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_sel   <= SEL_0;
      res_data  <= '0;
      done      <= 1'b0;
`ifdef OPSEQ_XOR_CHK_EN
      chk       <= '0;
`endif
    end else begin
      res_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_a  <= a_in;
            op_b  <= b_in;
            op_s  <= SEL_0;
            cnt   <= HOLD_M1;
            busy  <= 1'b1;
            state <= DRIVE;
`ifdef OPSEQ_XOR_CHK_EN
            chk   <= '0;
`endif
          end
        end
        DRIVE: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            res_valid <= 1'b1;
            res_sel   <= op_s;
            res_data  <= op_y;
`ifdef OPSEQ_XOR_CHK_EN
            chk       <= chk ^ op_y;
`endif
            // Last select exits via DONE so op_s never wraps here.
            if (op_s == SEL_3) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              op_s <= op_s + 2'd1;
              cnt  <= HOLD_M1;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_opseq_ctrl.sv
// Directed bench for opseq_ctrl with a stub op unit and a result scoreboard.
module tb_opseq_ctrl;

  localparam int W = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // dut: HOLD_CYCLES=2, dut1: HOLD_CYCLES=1
  logic         start, start1;
  logic [W-1:0] a_in, b_in, a_in1, b_in1;
  logic [1:0]   op_s, op_s1;
  logic [W-1:0] op_a, op_b, op_y, op_a1, op_b1, op_y1;
  logic         busy, res_valid, done, busy1, res_valid1, done1;
  logic [1:0]   res_sel, res_sel1, rd_sel, rd_sel1;
  logic [W-1:0] res_data, res_data1, rd_data, rd_data1;
`ifdef OPSEQ_XOR_CHK_EN
  logic [W-1:0] chk, chk1;
`endif

  function automatic logic [W-1:0] opf(input logic [1:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
    case (s)
      2'b00:   return a;
      2'b01:   return b;
      2'b10:   return a & b;
      default: return a | b;
    endcase
  endfunction

  assign op_y  = opf(op_s, op_a, op_b);
  assign op_y1 = opf(op_s1, op_a1, op_b1);

  opseq_ctrl #(.W(W), .HOLD_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .op_s(op_s), .op_a(op_a), .op_b(op_b), .op_y(op_y),
    .busy(busy), .res_valid(res_valid), .res_sel(res_sel), .res_data(res_data),
    .rd_sel(rd_sel), .rd_data(rd_data),
`ifdef OPSEQ_XOR_CHK_EN
    .chk(chk),
`endif
    .done(done)
  );

  opseq_ctrl #(.W(W), .HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a_in(a_in1), .b_in(b_in1),
    .op_s(op_s1), .op_a(op_a1), .op_b(op_b1), .op_y(op_y1),
    .busy(busy1), .res_valid(res_valid1), .res_sel(res_sel1), .res_data(res_data1),
    .rd_sel(rd_sel1), .rd_data(rd_data1),
`ifdef OPSEQ_XOR_CHK_EN
    .chk(chk1),
`endif
    .done(done1)
  );

  typedef struct packed {
    logic [1:0]   sel;
    logic [W-1:0] data;
  } res_t;

  res_t q0[$];
  res_t q1[$];
  int   cap0[$];
  int   cap1[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic chk_nz;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int which, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t e;
    for (int s = 0; s < 4; s++) begin
      e.sel  = 2'(s);
      e.data = opf(2'(s), a, b);
      if (which == 0) q0.push_back(e);
      else            q1.push_back(e);
    end
  endtask

  // Scoreboard: every captured result must match the oldest expected entry.
  always @(negedge clk) begin
    res_t e;
    if (res_valid === 1'b1) begin
      cap0.push_back(cyc);
      check("res0_expected_present", 32'(q0.size() != 0), 32'd1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        check("res0_sel", 32'(res_sel), 32'(e.sel));
        check("res0_data", 32'(res_data), 32'(e.data));
      end
    end
    if (res_valid1 === 1'b1) begin
      cap1.push_back(cyc);
      check("res1_expected_present", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        check("res1_sel", 32'(res_sel1), 32'(e.sel));
        check("res1_data", 32'(res_data1), 32'(e.data));
      end
    end
  end

  // Single start pulse on dut, returns edges until done (0 on timeout).
  task automatic run0(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    a_in = a;
    b_in = b;
    push_exp(0, a, b);
    start = 1'b1;
    lat = 0;
    chk_nz = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      start = 1'b0;
`ifdef OPSEQ_XOR_CHK_EN
      if (chk !== '0) chk_nz = 1'b1;
`endif
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int nc;
    int nd;
    rst = 1'b1;
    start = 1'b0; a_in = '0; b_in = '0; rd_sel = '0;
    start1 = 1'b0; a_in1 = '0; b_in1 = '0; rd_sel1 = '0;
    chk_nz = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ops", {op_s, op_a, op_b}, 32'd0);
    check("rst_res", {res_valid, res_sel, res_data, done}, 32'd0);
    check("rst_busy1", 32'(busy1), 32'd0);
`ifdef OPSEQ_XOR_CHK_EN
    check("rst_chk", 32'(chk), 32'd0);
`endif
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i); #1;
      check("rst_bank", 32'(rd_data), 32'd0);
    end
    rst = 1'b0;
    tick();

    // Scenario 1: basic sequence
    cap0.delete();
    run0(5'b00101, 5'b01010, lat);
    check("s1_done_latency", lat, 32'd9);
    tick();
    check("s1_q_drained", q0.size(), 32'd0);
    check("s1_cap_count", cap0.size(), 32'd4);
    for (int i = 0; i < 3; i++)
      if (cap0.size() == 4) check("s1_cap_spacing", cap0[i+1] - cap0[i], 32'd2);
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i); #1;
      check("s1_bank_read", 32'(rd_data), 32'(opf(2'(i), 5'b00101, 5'b01010)));
    end
`ifdef OPSEQ_XOR_CHK_EN
    check("s5_chk_run1", 32'(chk), 32'd0);
`endif

    // Scenario 2: start held high while busy, operand changes mid-run
    a_in = 5'b00101; b_in = 5'b01010;
    push_exp(0, 5'b00101, 5'b01010);
    start = 1'b1;
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (k == 3) a_in = 5'b11111;
      if (busy === 1'b1) check("s2_op_a_held", 32'(op_a), 32'b00101);
      if (done === 1'b1) begin lat = k; break; end
    end
    check("s2_done_latency", lat, 32'd9);
    push_exp(0, 5'b11111, 5'b01010);
    tick();
    check("s2_idle_gap_busy", 32'(busy), 32'd0);
    tick();
    check("s2_restart_busy", 32'(busy), 32'd1);
    check("s2_restart_op_a", 32'(op_a), 32'b11111);
    start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (done === 1'b1) begin lat = k; break; end
    end
    check("s2_run2_latency", lat, 32'd8);
    tick();
    check("s2_q_drained", q0.size(), 32'd0);

    // Scenario 3: reset after the 2nd capture
    a_in = 5'b00101; b_in = 5'b01010;
    push_exp(0, 5'b00101, 5'b01010);
    start = 1'b1;
    nc = 0;
    for (int k = 1; k <= 50; k++) begin
      tick();
      start = 1'b0;
      if (res_valid === 1'b1) nc++;
      if (nc == 2) break;
    end
    check("s3_two_caps", nc, 32'd2);
    rst = 1'b1;
    tick();
    q0.delete();
    check("s3_busy", 32'(busy), 32'd0);
    check("s3_op_s", 32'(op_s), 32'd0);
    check("s3_outs", {res_valid, done, op_a, op_b}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i); #1;
      check("s3_bank_clear", 32'(rd_data), 32'd0);
    end
    rst = 1'b0;
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) nd++;
    end
    check("s3_no_done", nd, 32'd0);

    // Scenario 5: checksum with a non-trivial intermediate value
    run0(5'b00111, 5'b00011, lat);
    check("s6_pre_latency", lat, 32'd9);
`ifdef OPSEQ_XOR_CHK_EN
    check("s5_chk_run2", 32'(chk), 32'd0);
    check("s5_chk_toggled", 32'(chk_nz), 32'd1);
`endif
    tick();

    // Scenario 6: idle stability after a completed run
    for (int k = 0; k < 20; k++) begin
      tick();
      check("s6_idle", {op_s, op_a, op_b, res_valid, done, busy}, {2'b11, 5'b00111, 5'b00011, 3'b000});
    end
    check("s6_q_drained", q0.size(), 32'd0);

    // Scenario 4: minimum hold on dut1
    cap1.delete();
    a_in1 = 5'b00101; b_in1 = 5'b01010;
    push_exp(1, 5'b00101, 5'b01010);
    start1 = 1'b1;
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      start1 = 1'b0;
      if (done1 === 1'b1) begin lat = k; break; end
    end
    check("s4_done_latency", lat, 32'd5);
    tick();
    check("s4_q_drained", q1.size(), 32'd0);
    check("s4_cap_count", cap1.size(), 32'd4);
    for (int i = 0; i < 3; i++)
      if (cap1.size() == 4) check("s4_cap_spacing", cap1[i+1] - cap1[i], 32'd1);
    for (int i = 0; i < 4; i++) begin
      rd_sel1 = 2'(i); #1;
      check("s4_bank_read", 32'(rd_data1), 32'(opf(2'(i), 5'b00101, 5'b01010)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
